// File: rtl/hash_w_pkg.sv
// Shared types and constants for the SHA-2 message schedule (hash_w_sched).
package hash_w_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PAD   = 2'd2,
        ST_SCHED = 2'd3
    } state_e;

    typedef enum logic {
        MODE_256 = 1'b0,
        MODE_512 = 1'b1
    } mode_e;

    localparam int WIN_WORDS     = 16;
    localparam int R_256         = 64;
    localparam int R_512         = 80;
    localparam int BLK_BYTES_256 = 64;
    localparam int BLK_BYTES_512 = 128;
    localparam int BEATS_256     = BLK_BYTES_256 / 8;
    localparam int BEATS_512     = BLK_BYTES_512 / 8;
    localparam int LEN_BYTES_256 = 8;
    localparam int LEN_BYTES_512 = 16;

    // Last round index and last beat index of a block, as narrow vectors.
    function automatic logic [6:0] last_round(mode_e m);
        return (m == MODE_512) ? 7'(R_512 - 1) : 7'(R_256 - 1);
    endfunction

    function automatic logic [3:0] last_beat(mode_e m);
        return (m == MODE_512) ? 4'(BEATS_512 - 1) : 4'(BEATS_256 - 1);
    endfunction

endpackage

// File: rtl/hash_w_sig.sv
// Next schedule word: sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16].
// 32-bit words are left-aligned in [63:32]; 64-bit path only with HASH_W_SCHED_SHA512_EN.
module hash_w_sig
    import hash_w_pkg::*;
(
    input  mode_e       mode,
    input  logic [63:0] w_m2,
    input  logic [63:0] w_m7,
    input  logic [63:0] w_m15,
    input  logic [63:0] w_m16,
    output logic [63:0] w_next
);

    logic [31:0] a32, b32, s0_32, s1_32, sum32;

    assign a32   = w_m15[63:32];
    assign b32   = w_m2[63:32];
    assign s0_32 = {a32[6:0], a32[31:7]} ^ {a32[17:0], a32[31:18]} ^ (a32 >> 3);
    assign s1_32 = {b32[16:0], b32[31:17]} ^ {b32[18:0], b32[31:19]} ^ (b32 >> 10);
    assign sum32 = s1_32 + w_m7[63:32] + s0_32 + w_m16[63:32];

`ifdef HASH_W_SCHED_SHA512_EN
    logic [63:0] s0_64, s1_64, sum64;

    assign s0_64 = {w_m15[0], w_m15[63:1]} ^ {w_m15[7:0], w_m15[63:8]} ^ (w_m15 >> 7);
    assign s1_64 = {w_m2[18:0], w_m2[63:19]} ^ {w_m2[60:0], w_m2[63:61]} ^ (w_m2 >> 6);
    assign sum64 = s1_64 + w_m7 + s0_64 + w_m16;

    always_comb begin
        w_next = {sum32, 32'h0};
        if (mode == MODE_512) begin
            w_next = sum64;
        end
    end
`else
    logic unused_lo;
    assign unused_lo = ^{mode, w_m2[31:0], w_m7[31:0], w_m15[31:0], w_m16[31:0]};
    assign w_next    = {sum32, 32'h0};
`endif

endmodule

// File: rtl/hash_w_sched.sv
// SHA-2 message padding and W_t schedule generator (16-word sliding window).
// HASH_W_SCHED_SHA512_EN enables mode 1 (SHA-384/512); otherwise mode is forced to 0.
module hash_w_sched
    import hash_w_pkg::*;
#(
    parameter int LEN_W = 64,
    parameter int RST_W = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        mode,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [63:0] m_data,
    input  logic        m_last,
    input  logic [3:0]  m_nbytes,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [63:0] w,
    output logic [6:0]  w_t,
    output logic        blk_last,
    output logic        len_err
);

    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // valid never depends on ready, and the payload is held until it is taken.

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d, in_mode, beat_mode;
    logic [3:0]       beat_q, beat_d;
    logic [6:0]       pos_q, pos_d;
    logic [6:0]       t_q, t_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             len_err_q, len_err_d;
    logic             pad80_q, pad80_d;
    logic             pad_pend_q, pad_pend_d;
    logic             blk_last_q, blk_last_d;
    logic [63:0]      win_q [WIN_WORDS];
    logic [63:0]      win_d [WIN_WORDS];

    logic [63:0]      w_next;
    logic [3:0]       nb;
    logic             blk_full;
    logic [LEN_W:0]   cnt_sum;
    logic [127:0]     bit_len;
    logic             pad_fits;
    logic [7:0]       pad_byte [WIN_WORDS][8];
    logic [63:0]      pad_win  [WIN_WORDS];

`ifdef HASH_W_SCHED_SHA512_EN
    assign in_mode = mode_e'(mode);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign in_mode     = MODE_256;
`endif

    assign m_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign w_valid  = (state_q == ST_SCHED);
    assign w        = w_valid ? win_q[0] : 64'h0;
    assign w_t      = t_q;
    assign blk_last = blk_last_q;
    assign len_err  = len_err_q;

    assign beat_mode = (state_q == ST_IDLE) ? in_mode : mode_q;
    assign nb        = m_last ? ((m_nbytes > 4'd8) ? 4'd8 : m_nbytes) : 4'd8;
    assign blk_full  = (nb == 4'd8) && (beat_q == last_beat(beat_mode));
    assign cnt_sum   = {1'b0, cnt_q} + {{(LEN_W-3){1'b0}}, nb};
    assign bit_len   = 128'({cnt_q, 3'b000});

    // After a 0x80 already went out, the length always fits in the fresh block.
    assign pad_fits = pad80_q || ((mode_q == MODE_512) ? (pos_q <= 7'd111) : (pos_q <= 7'd55));

    hash_w_sig u_sig (
        .mode   (mode_q),
        .w_m2   (win_q[14]),
        .w_m7   (win_q[9]),
        .w_m15  (win_q[1]),
        .w_m16  (win_q[0]),
        .w_next (w_next)
    );

    // Padded block, one byte lane at a time; B0/B1 are block byte offsets per mode.
    for (genvar gi = 0; gi < WIN_WORDS; gi++) begin : g_word
        for (genvar gl = 0; gl < 8; gl++) begin : g_lane
            localparam int B0 = gi * 4 + gl;
            localparam int B1 = gi * 8 + gl;
            localparam logic [6:0] B0V = 7'(B0);
            localparam logic [6:0] B1V = 7'(B1);
            localparam int L0 = (B0 >= 56 && B0 < 64) ? (63 - B0) : 0;
            localparam int L1 = (B1 >= 112) ? (127 - B1) : 0;
            logic [7:0] byte0, byte1;

            if (gl < 4) begin : g_m0
                assign byte0 = (B0V < pos_q) ? win_q[gi][63-8*gl -: 8] :
                               ((B0V == pos_q) && !pad80_q) ? 8'h80 :
                               (pad_fits && (B0 >= 56)) ? bit_len[8*L0 +: 8] : 8'h00;
            end else begin : g_z0
                assign byte0 = 8'h00;
            end

            assign byte1 = (B1V < pos_q) ? win_q[gi][63-8*gl -: 8] :
                           ((B1V == pos_q) && !pad80_q) ? 8'h80 :
                           (pad_fits && (B1 >= 112)) ? bit_len[8*L1 +: 8] : 8'h00;

            assign pad_byte[gi][gl] = (mode_q == MODE_512) ? byte1 : byte0;
        end
        assign pad_win[gi] = {pad_byte[gi][0], pad_byte[gi][1], pad_byte[gi][2], pad_byte[gi][3],
                              pad_byte[gi][4], pad_byte[gi][5], pad_byte[gi][6], pad_byte[gi][7]};
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        beat_d     = beat_q;
        pos_d      = pos_q;
        t_d        = t_q;
        cnt_d      = cnt_q;
        len_err_d  = len_err_q;
        pad80_d    = pad80_q;
        pad_pend_d = pad_pend_q;
        blk_last_d = blk_last_q;
        win_d      = win_q;

        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (m_valid) begin
                    mode_d = beat_mode;
                    cnt_d  = cnt_sum[LEN_W-1:0];
                    if (cnt_sum[LEN_W]) begin
                        len_err_d = 1'b1;
                    end
                    // Bytes past the end of a short beat are cleaned up in PAD.
                    if (beat_mode == MODE_512) begin
                        win_d[beat_q] = m_data;
                    end else begin
                        win_d[{beat_q[2:0], 1'b0}] = {m_data[63:32], 32'h0};
                        win_d[{beat_q[2:0], 1'b1}] = {m_data[31:0], 32'h0};
                    end
                    if (blk_full) begin
                        state_d = ST_SCHED;
                        beat_d  = 4'd0;
                        if (m_last) begin
                            pad_pend_d = 1'b1;
                            pos_d      = 7'd0;
                        end
                    end else if (m_last) begin
                        state_d = ST_PAD;
                        pos_d   = {beat_q, 3'b000} + {3'b000, nb};
                    end else begin
                        state_d = ST_LOAD;
                        beat_d  = beat_q + 4'd1;
                    end
                end
            end
            ST_PAD: begin
                win_d   = pad_win;
                pad80_d = 1'b1;
                state_d = ST_SCHED;
                if (pad_fits) begin
                    blk_last_d = 1'b1;
                end else begin
                    pad_pend_d = 1'b1;
                    pos_d      = 7'd0;
                end
            end
            ST_SCHED: begin
                if (w_ready) begin
                    for (int i = 0; i < WIN_WORDS - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[WIN_WORDS-1] = w_next;
                    t_d = t_q + 7'd1;
                    if (t_q == last_round(mode_q)) begin
                        t_d = 7'd0;
                        if (pad_pend_q) begin
                            state_d    = ST_PAD;
                            pad_pend_d = 1'b0;
                        end else if (blk_last_q) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            pad80_d    = 1'b0;
                            blk_last_d = 1'b0;
                            beat_d     = 4'd0;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
        endcase

        if (clr) begin
            state_d    = ST_IDLE;
            mode_d     = MODE_256;
            beat_d     = 4'd0;
            pos_d      = 7'd0;
            t_d        = 7'd0;
            cnt_d      = '0;
            len_err_d  = 1'b0;
            pad80_d    = 1'b0;
            pad_pend_d = 1'b0;
            blk_last_d = 1'b0;
            win_d      = win_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_256;
            beat_q     <= 4'd0;
            pos_q      <= 7'd0;
            t_q        <= 7'd0;
            cnt_q      <= '0;
            len_err_q  <= 1'b0;
            pad80_q    <= 1'b0;
            pad_pend_q <= 1'b0;
            blk_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            beat_q     <= beat_d;
            pos_q      <= pos_d;
            t_q        <= t_d;
            cnt_q      <= cnt_d;
            len_err_q  <= len_err_d;
            pad80_q    <= pad80_d;
            pad_pend_q <= pad_pend_d;
            blk_last_q <= blk_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && (RST_W != 0)) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            win_q <= win_d;
        end
    end

endmodule

// File: tb/tb_hash_w_sched.sv
// Self-checking bench for hash_w_sched: SHA-2 padding/schedule reference model plus scoreboard.
module tb_hash_w_sched;

  logic        clk = 1'b0;
  logic        rst, clr, mode, m_valid, m_ready, m_last, w_valid, w_ready, blk_last, len_err;
  logic [63:0] m_data, w;
  logic [3:0]  m_nbytes;
  logic [6:0]  w_t;

`ifdef HASH_W_SCHED_SHA512_EN
  localparam bit HAS512 = 1'b1;
`else
  localparam bit HAS512 = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hash_w_sched #(.LEN_W(64), .RST_W(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_nbytes(m_nbytes),
    .w_valid(w_valid), .w_ready(w_ready), .w(w), .w_t(w_t), .blk_last(blk_last), .len_err(len_err)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [63:0] exp_w_q[$];
  logic [6:0]  exp_t_q[$];
  logic        exp_l_q[$];

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic model_push(input logic [7:0] msg[$], input bit md);
    logic [7:0]   p[$];
    logic [127:0] bl;
    logic [63:0]  ww[80];
    logic [63:0]  x2, x15;
    logic [31:0]  s;
    int bb, lb, r, nblk;
    bb = md ? 128 : 64;
    lb = md ? 16 : 8;
    r  = md ? 80 : 64;
    p  = msg;
    p.push_back(8'h80);
    while ((p.size() % bb) != (bb - lb)) p.push_back(8'h00);
    bl = 128'(msg.size()) << 3;
    for (int k = lb - 1; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nblk = p.size() / bb;
    for (int b = 0; b < nblk; b++) begin
      for (int t = 0; t < 16; t++) begin
        ww[t] = 64'h0;
        for (int j = 0; j < (md ? 8 : 4); j++) ww[t] = (ww[t] << 8) | 64'(p[b*bb + t*(md ? 8 : 4) + j]);
      end
      for (int t = 16; t < r; t++) begin
        x2  = ww[t-2];
        x15 = ww[t-15];
        if (md) begin
          ww[t] = (rotr64(x2, 19) ^ rotr64(x2, 61) ^ (x2 >> 6)) + ww[t-7]
                + (rotr64(x15, 1) ^ rotr64(x15, 8) ^ (x15 >> 7)) + ww[t-16];
        end else begin
          s = (rotr32(x2[31:0], 17) ^ rotr32(x2[31:0], 19) ^ (x2[31:0] >> 10)) + ww[t-7][31:0]
            + (rotr32(x15[31:0], 7) ^ rotr32(x15[31:0], 18) ^ (x15[31:0] >> 3)) + ww[t-16][31:0];
          ww[t] = {32'h0, s};
        end
      end
      for (int t = 0; t < r; t++) begin
        exp_w_q.push_back(md ? ww[t] : {ww[t][31:0], 32'h0});
        exp_t_q.push_back(7'(t));
        exp_l_q.push_back(b == nblk - 1);
      end
    end
  endtask

  // ---------------- W-side monitor (drives w_ready and clr) ----------------
  int          rdy_mode  = 0;
  int          clr_at_t  = -1;
  bit          clr_done  = 1'b0;
  bit          post_clr  = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] held_w;
  logic [6:0]  held_t;
  logic        held_l;
  logic [63:0] cap_w[80];
  int          n_blocks = 0;
  int          last_t   = 0;

  initial begin
    w_ready = 1'b0;
    clr     = 1'b0;
    forever begin
      @(negedge clk);
      if (post_clr) begin
        post_clr = 1'b0;
        clr      = 1'b0;
        check("clr_w_valid", 64'(w_valid), 64'd0);
        check("clr_m_ready", 64'(m_ready), 64'd1);
      end
      if (stall_prev && w_valid) begin
        check("stall_w", w, held_w);
        check("stall_t", 64'(w_t), 64'(held_t));
        check("stall_blk_last", 64'(blk_last), 64'(held_l));
      end
      case (rdy_mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ~w_ready;
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      if (w_valid && (clr_at_t >= 0) && (int'(w_t) == clr_at_t)) begin
        clr = 1'b1;
        exp_w_q.delete();
        exp_t_q.delete();
        exp_l_q.delete();
        clr_at_t   = -1;
        clr_done   = 1'b1;
        post_clr   = 1'b1;
        stall_prev = 1'b0;
      end else if (w_valid && w_ready) begin
        stall_prev = 1'b0;
        if (exp_w_q.size() == 0) begin
          check("sb_underflow", 64'(exp_w_q.size()), 64'd1);
        end else begin
          check("w", w, exp_w_q.pop_front());
          check("w_t", 64'(w_t), 64'(exp_t_q.pop_front()));
          check("blk_last", 64'(blk_last), 64'(exp_l_q.pop_front()));
        end
        if (w_t == 7'd0) n_blocks++;
        if (w_t < 7'd80) cap_w[w_t] = w;
        last_t = int'(w_t);
      end else if (w_valid) begin
        stall_prev = 1'b1;
        held_w = w;
        held_t = w_t;
        held_l = blk_last;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // ---------------- message-side driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input bit last, input logic [3:0] nb);
    int n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    m_valid  = 1'b1;
    m_data   = d;
    m_last   = last;
    m_nbytes = nb;
    while (!m_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("beat_accept_timeout", 64'(m_ready), 64'd1);
    @(negedge clk);
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_nbytes = 4'($urandom_range(0, 15));
    m_data   = {$urandom, $urandom};
    mode     = 1'($urandom_range(0, 1));
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit md, input bit tail);
    int n, i, nb;
    logic [63:0] d;
    bit last;
    n = msg.size();
    i = 0;
    mode = md;
    if (n == 0) send_beat({$urandom, $urandom}, 1'b1, 4'd0);
    while (i < n) begin
      nb = (n - i >= 8) ? 8 : (n - i);
      d  = {$urandom, $urandom};
      for (int j = 0; j < nb; j++) d[63-8*j -: 8] = msg[i+j];
      last = (i + nb == n) && !(tail && nb == 8);
      send_beat(d, last, last ? 4'(nb) : 4'd8);
      i += nb;
    end
    if (n > 0 && tail && (n % 8) == 0) send_beat({$urandom, $urandom}, 1'b1, 4'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_w_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(exp_w_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, "_idle_m_ready"}, 64'(m_ready), 64'd1);
    check({tag, "_idle_w_valid"}, 64'(w_valid), 64'd0);
    check({tag, "_len_err"}, 64'(len_err), 64'd0);
  endtask

  task automatic run_msg(input string tag, input logic [7:0] msg[$], input bit md, input bit tail);
    n_blocks = 0;
    model_push(msg, md & HAS512);
    send_msg(msg, md, tail);
    wait_drain(tag);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] abc[$];
  logic [7:0] msg[$];
  logic [7:0] none[$];

  initial begin
    rst = 1'b1; mode = 1'b0; m_valid = 1'b0; m_data = 64'h0; m_last = 1'b0; m_nbytes = 4'd0;
    abc = '{8'h61, 8'h62, 8'h63};
    repeat (2) @(negedge clk);
    check("rst_m_ready", 64'(m_ready), 64'd1);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_w", w, 64'h0);
    check("rst_w_t", 64'(w_t), 64'd0);
    check("rst_blk_last", 64'(blk_last), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    rdy_mode = 0;
    run_msg("abc256", abc, 1'b0, 1'b0);
    check("abc256_w0", cap_w[0], 64'h61626380_00000000);
    check("abc256_w14", cap_w[14], 64'h0);
    check("abc256_w15", cap_w[15], 64'h00000018_00000000);
    check("abc256_w16", cap_w[16], 64'h61626380_00000000);
    check("abc256_w17", cap_w[17], 64'h000F0000_00000000);
    check("abc256_last_t", 64'(last_t), 64'd63);
    check("abc256_blocks", 64'(n_blocks), 64'd1);

    run_msg("abc512", abc, 1'b1, 1'b0);
    check("abc512_w0", cap_w[0], 64'h61626380_00000000);
    check("abc512_w15", cap_w[15], HAS512 ? 64'h18 : 64'h00000018_00000000);
    check("abc512_last_t", 64'(last_t), HAS512 ? 64'd79 : 64'd63);

    run_msg("empty", none, 1'b0, 1'b0);
    check("empty_w0", cap_w[0], 64'h80000000_00000000);
    check("empty_w15", cap_w[15], 64'h0);
    check("empty_blocks", 64'(n_blocks), 64'd1);

    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'($urandom));
    run_msg("len55", msg, 1'b0, 1'b0);
    check("len55_w15", cap_w[15], 64'h000001B8_00000000);
    check("len55_blocks", 64'(n_blocks), 64'd1);

    msg.push_back(8'($urandom));
    run_msg("len56", msg, 1'b0, 1'b0);
    check("len56_w0", cap_w[0], 64'h0);
    check("len56_w15", cap_w[15], 64'h000001C0_00000000);
    check("len56_blocks", 64'(n_blocks), 64'd2);

    rdy_mode = 1;
    run_msg("toggle", abc, 1'b0, 1'b0);
    check("toggle_w16", cap_w[16], 64'h61626380_00000000);
    check("toggle_w17", cap_w[17], 64'h000F0000_00000000);

    begin
      int n = 0;
      rdy_mode = 0;
      clr_done = 1'b0;
      clr_at_t = 20;
      model_push(abc, 1'b0);
      send_msg(abc, 1'b0, 1'b0);
      while (!clr_done && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("clr_seen", 64'(clr_done), 64'd1);
      repeat (3) @(negedge clk);
      run_msg("after_clr", abc, 1'b0, 1'b0);
      check("after_clr_w16", cap_w[16], 64'h61626380_00000000);
      check("after_clr_w17", cap_w[17], 64'h000F0000_00000000);
    end

    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 1'b0, 4'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_m_ready", 64'(m_ready), 64'd1);
    check("midrst_w_valid", 64'(w_valid), 64'd0);
    check("midrst_w_t", 64'(w_t), 64'd0);
    run_msg("after_rst", abc, 1'b0, 1'b0);
    check("after_rst_w17", cap_w[17], 64'h000F0000_00000000);

    for (int k = 0; k < 25; k++) begin
      bit md, tail;
      msg.delete();
      for (int i = 0; i < int'($urandom_range(0, 300)); i++) msg.push_back(8'($urandom));
      md       = 1'($urandom_range(0, 1));
      tail     = 1'($urandom_range(0, 1));
      rdy_mode = int'($urandom_range(0, 2));
      run_msg("rand", msg, md, tail);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
